hilo_divider: RTL and testbench
===============================

// Module: hilo_divider
// PURPOSE
//   Execute-stage responder to the decoder's HasDivD / is_mf_hi / is_mf_lo controls.
//   Runs a multi-cycle signed 32-bit restoring divide, one quotient bit per cycle.
//   Owns the architectural HI/LO registers and returns HI/LO for MFHI/MFLO.
//   Raises a stall to the hazard unit while a result is pending.
// PARAMETERS
//   WIDTH  32  operand/HI/LO width; iteration count = WIDTH
// PORTS
//   clock      in   1      single system clock, rising edge
//   reset      in   1      asynchronous, active-high
//   start_div  in   1      HasDivE: DIV instruction in execute stage
//   dividend   in   WIDTH  rs value (signed), sampled on accepted start
//   divisor    in   WIDTH  rt value (signed), sampled on accepted start
//   mf_hi      in   1      is_mf_hi in execute stage
//   mf_lo      in   1      is_mf_lo in execute stage
//   mf_value   out  WIDTH  HI if mf_hi, LO if mf_lo, else 0 (combinational)
//   busy       out  1      1 while state != IDLE
//   div_stall  out  1      busy & (start_div | mf_hi | mf_lo)
//   hi         out  WIDTH  architectural HI (remainder)
//   lo         out  WIDTH  architectural LO (quotient)
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, hi=lo=0, counter=0, busy=0, stall=0; an in-flight divide is discarded.
//   States: IDLE, RUN, FIX.
//   IDLE: start_div sampled high at an edge -> latch |dividend|, |divisor|, quotient sign (sa^sb), remainder sign (sa), counter=WIDTH-1.
//     divisor==0 -> FIX directly (skip RUN). Otherwise -> RUN.
//   RUN: one restoring step per cycle: rem={rem[W-2:0],a[msb]}; if rem>=|b| subtract and shift 1 into q, else shift 0.
//     counter==0 at the edge -> FIX, else counter-1. Exactly WIDTH cycles in RUN.
//   FIX: one cycle, applies signs; hi/lo are written at the FIX->IDLE edge.
//   Latency: start edge E0 -> hi/lo valid after edge E0+WIDTH+1 (33 edges for WIDTH=32). busy is high for those cycles.
//   Semantics: quotient truncates toward zero; remainder takes the dividend's sign.
//   Divide by zero: lo=all-ones, hi=dividend, busy for 1 cycle only.
//   Overflow 0x80000000 / -1: lo=0x80000000, hi=0. This is the natural unsigned-magnitude result; no special case.
//   Magnitude arithmetic is WIDTH-bit unsigned, so |0x80000000| = 0x80000000 is exact.
//   start_div while busy: ignored. div_stall holds the DIV in execute until IDLE, then it is accepted.
//   mf_hi/mf_lo while busy: stalled. They return the new value once busy falls, never stale data.
//   mf_hi & mf_lo together: illegal from the decoder. mf_hi takes priority.
//   mf while IDLE: no stall; mf_value = current hi/lo in the same cycle.
//   hi/lo change only at the FIX->IDLE edge or on reset.
// STRUCTURE
//   mips.h: `DIV_IDLE/`DIV_RUN/`DIV_FIX 2-bit state encodings; WIDTH default.
//   Sub-module div_step: combinational single restoring iteration.
//     Ports: (rem_in, q_in, divisor, rem_out, q_out).
//   Top level holds the FSM, counter, sign flags, hi/lo registers and stall logic.
// TESTING
//   100 / 7 -> after 33 cycles lo=14, hi=2; busy high exactly 33 cycles; mf_lo then returns 14 with no stall.
//   -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; 7 / -2 -> lo=0xFFFFFFFD, hi=1.
//   0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; 5 / 0 -> lo=0xFFFFFFFF, hi=5, busy 1 cycle.
//   mf_hi held from cycle 1 after start -> div_stall=1 until busy falls.
//     Next cycle: mf_value = new hi, stall=0.
//   Back-to-back DIV: second start_div held during busy -> stalled.
//     Accepted on the first IDLE cycle; second result overwrites the first.
//   reset asserted mid-RUN (cycle 10), no clock edge -> busy=0, hi=lo=0 immediately.
//     A subsequent 9/3 -> lo=3, hi=0.

Source files
------------

// File: rtl/hilo_divider_pkg.sv
// ============================================================================
// hilo_divider_pkg
//   Shared width default and divider state encoding for the HI/LO divider.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package hilo_divider_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIX  = 2'd2
    } div_state_t;

endpackage

`default_nettype wire

// File: rtl/hilo_divider_div_step.sv
// ============================================================================
// hilo_divider_div_step
//   One combinational restoring-division iteration on unsigned magnitudes.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module hilo_divider_div_step
    import hilo_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;

    // q_in carries the unconsumed dividend bits at the top and the quotient
    // bits being built at the bottom. The partial remainder is always below
    // the divisor, so the borrow bit of diff is an exact "shifted < divisor".
    always_comb begin
        shifted = {rem_in, q_in[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        fits    = ~diff[WIDTH];
        rem_out = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        q_out   = {q_in[WIDTH-2:0], fits};
    end

endmodule

`default_nettype wire

// File: rtl/hilo_divider.sv
// ============================================================================
// hilo_divider
//   Multi-cycle signed divide owning HI/LO, with MFHI/MFLO readback and stall.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module hilo_divider
    import hilo_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             mf_hi,
    input  logic             mf_lo,
    output logic [WIDTH-1:0] mf_value,
    output logic             busy,
    output logic             div_stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                    input logic             neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    div_state_t       state;
    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] quo_reg;
    logic [WIDTH-1:0] div_mag;
    logic             quo_neg;
    logic             rem_neg;
    logic             div_zero;

    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    hilo_divider_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in  (rem_reg),
        .q_in    (quo_reg),
        .divisor (div_mag),
        .rem_out (rem_next),
        .q_out   (quo_next)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= DIV_IDLE;
            counter  <= '0;
            rem_reg  <= '0;
            quo_reg  <= '0;
            div_mag  <= '0;
            quo_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start_div) begin
                        rem_reg  <= '0;
                        quo_reg  <= magnitude(dividend);
                        div_mag  <= magnitude(divisor);
                        quo_neg  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        rem_neg  <= dividend[WIDTH-1];
                        div_zero <= (divisor == '0);
                        counter  <= CNT_LAST;
                        state    <= (divisor == '0) ? DIV_FIX : DIV_RUN;
                    end
                end
                DIV_RUN: begin
                    rem_reg <= rem_next;
                    quo_reg <= quo_next;
                    if (counter == '0) begin
                        state <= DIV_FIX;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                DIV_FIX: begin
                    // On divide-by-zero quo_reg still holds |dividend| untouched,
                    // so re-signing it reproduces the original dividend for HI.
                    if (div_zero) begin
                        lo <= '1;
                        hi <= apply_sign(quo_reg, rem_neg);
                    end else begin
                        lo <= apply_sign(quo_reg, quo_neg);
                        hi <= apply_sign(rem_reg, rem_neg);
                    end
                    state <= DIV_IDLE;
                end
                default: begin
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != DIV_IDLE);
    assign div_stall = busy & (start_div | mf_hi | mf_lo);
    assign mf_value  = mf_hi ? hi : (mf_lo ? lo : '0);

endmodule

`default_nettype wire

// File: tb/tb_hilo_divider.sv
// ============================================================================
// tb_hilo_divider
//   Directed checks of the HI/LO divider against hand-computed results.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hilo_divider;

    logic        clock;
    logic        reset;
    logic        start_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        mf_hi;
    logic        mf_lo;
    logic [31:0] mf_value;
    logic        busy;
    logic        div_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int err_cnt = 0;
    int chk_cnt = 0;

    hilo_divider #(
        .WIDTH (32)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start_div (start_div),
        .dividend  (dividend),
        .divisor   (divisor),
        .mf_hi     (mf_hi),
        .mf_lo     (mf_lo),
        .mf_value  (mf_value),
        .busy      (busy),
        .div_stall (div_stall),
        .hi        (hi),
        .lo        (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Launches one divide at a falling edge and returns the number of
    // falling-edge samples with busy high; ends on the first idle sample.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, output int cyc);
        @(negedge clock);
        start_div = 1'b1;
        dividend  = a;
        divisor   = b;
        @(negedge clock);
        start_div = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clock);
        end
    endtask

    int cyc;
    int stall_low;

    initial begin
        reset     = 1'b1;
        start_div = 1'b0;
        dividend  = '0;
        divisor   = '0;
        mf_hi     = 1'b0;
        mf_lo     = 1'b0;
        #1;
        check("reset_busy",  {31'd0, busy},      32'd0);
        check("reset_stall", {31'd0, div_stall}, 32'd0);
        check("reset_hi",    hi,                 32'd0);
        check("reset_lo",    lo,                 32'd0);
        check("reset_mf",    mf_value,           32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // 100 / 7
        run_div(32'd100, 32'd7, cyc);
        check("p7_cycles", cyc, 32'd33);
        check("p7_lo", lo, 32'd14);
        check("p7_hi", hi, 32'd2);
        mf_lo = 1'b1;
        #1;
        check("p7_mflo",  mf_value,           32'd14);
        check("p7_stall", {31'd0, div_stall}, 32'd0);
        mf_hi = 1'b1;
        #1;
        check("mf_prio", mf_value, 32'd2);
        mf_hi = 1'b0;
        mf_lo = 1'b0;
        #1;
        check("mf_none", mf_value, 32'd0);

        // sign handling
        run_div(32'hFFFF_FFF9, 32'd2, cyc);
        check("n7p2_lo", lo, 32'hFFFF_FFFD);
        check("n7p2_hi", hi, 32'hFFFF_FFFF);
        run_div(32'd7, 32'hFFFF_FFFE, cyc);
        check("p7n2_lo", lo, 32'hFFFF_FFFD);
        check("p7n2_hi", hi, 32'd1);

        // overflow and divide-by-zero
        run_div(32'h8000_0000, 32'hFFFF_FFFF, cyc);
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'd0);
        run_div(32'd5, 32'd0, cyc);
        check("dz_cycles", cyc, 32'd1);
        check("dz_lo", lo, 32'hFFFF_FFFF);
        check("dz_hi", hi, 32'd5);
        run_div(32'hFFFF_FFF6, 32'd0, cyc);
        check("dzneg_hi", hi, 32'hFFFF_FFF6);

        // mf_hi held while the divide runs: 50 / 3 -> q=16 r=2
        @(negedge clock);
        start_div = 1'b1;
        dividend  = 32'd50;
        divisor   = 32'd3;
        @(negedge clock);
        start_div = 1'b0;
        mf_hi     = 1'b1;
        cyc = 0;
        stall_low = 0;
        while (busy && cyc < 100) begin
            if (!div_stall) stall_low++;
            cyc++;
            @(negedge clock);
        end
        check("mfh_stall_held", stall_low, 32'd0);
        check("mfh_cycles", cyc, 32'd33);
        check("mfh_value", mf_value, 32'd2);
        check("mfh_stall_off", {31'd0, div_stall}, 32'd0);
        mf_hi = 1'b0;

        // back-to-back: 100/7 then 23/6 held under stall
        @(negedge clock);
        start_div = 1'b1;
        dividend  = 32'd100;
        divisor   = 32'd7;
        @(negedge clock);
        dividend  = 32'd23;
        divisor   = 32'd6;
        cyc = 0;
        stall_low = 0;
        while (busy && cyc < 100) begin
            if (!div_stall) stall_low++;
            cyc++;
            @(negedge clock);
        end
        check("b2b_stall_held", stall_low, 32'd0);
        check("b2b_cycles1", cyc, 32'd33);
        check("b2b_lo1", lo, 32'd14);
        check("b2b_hi1", hi, 32'd2);
        check("b2b_idle_stall", {31'd0, div_stall}, 32'd0);
        @(negedge clock);
        start_div = 1'b0;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clock);
        end
        check("b2b_cycles2", cyc, 32'd33);
        check("b2b_lo2", lo, 32'd3);
        check("b2b_hi2", hi, 32'd5);

        // reset mid-RUN, away from any clock edge
        @(negedge clock);
        start_div = 1'b1;
        dividend  = 32'd100;
        divisor   = 32'd7;
        @(negedge clock);
        start_div = 1'b0;
        repeat (9) @(negedge clock);
        check("mid_busy_before", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_hi", hi, 32'd0);
        check("mid_lo", lo, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        run_div(32'd9, 32'd3, cyc);
        check("post_lo", lo, 32'd3);
        check("post_hi", hi, 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

`default_nettype wire
